// File: rtl/ram_sp_be_pipe.sv
// Single-port RAM with per-column write enables, a 1- or 2-stage registered read path,
// a read-valid strobe with read-data hold, and a clear sequencer that sweeps the array.
module ram_sp_be_pipe #(
  parameter int                ADR_WD   = 11,
  parameter int                DEPTH    = 1536,
  parameter int                DAT_WD   = 32,
  parameter int                COL_WD   = 8,
  parameter int                RD_LAT   = 1,
  parameter int                INIT_CLR = 1,
  parameter logic [DAT_WD-1:0] CLR_VAL  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADR_WD-1:0]        adr_i,
  input  logic                     wr_ena_i,
  input  logic [DAT_WD/COL_WD-1:0] wr_col_i,
  input  logic [DAT_WD-1:0]        wr_dat_i,
  input  logic                     rd_ena_i,
  output logic [DAT_WD-1:0]        rd_dat_o,
  output logic                     rd_val_o,
  input  logic                     clr_i,
  output logic                     busy_o
);

  localparam int NCOL = DAT_WD / COL_WD;

  if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
    $error("ram_sp_be_pipe: RD_LAT must be 1 or 2");
  end
  if ((DAT_WD % COL_WD) != 0) begin : g_bad_col_wd
    $error("ram_sp_be_pipe: DAT_WD must be a multiple of COL_WD");
  end
  if (DEPTH > (2 ** ADR_WD)) begin : g_bad_depth
    $error("ram_sp_be_pipe: DEPTH exceeds 2**ADR_WD");
  end

  typedef enum logic {IDLE = 1'b0, CLR = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADR_WD-1:0]   cnt_q, cnt_d;
  logic [DAT_WD-1:0]   mem [DEPTH];

  logic                in_rng;
  logic                rd_acc;
  logic [DAT_WD-1:0]   rd_word;
  logic                mem_we;
  logic [ADR_WD-1:0]   mem_adr;
  logic [NCOL-1:0]     mem_col;
  logic [DAT_WD-1:0]   mem_wdat;

  logic                s1_val_q, s1_val_d;
  logic [DAT_WD-1:0]   s1_dat_q, s1_dat_d;
  logic                s2_val_q, s2_val_d;
  logic [DAT_WD-1:0]   s2_dat_q, s2_dat_d;

  // Extra top bit so DEPTH == 2**ADR_WD is representable.
  assign in_rng  = ({1'b0, adr_i} < (ADR_WD + 1)'(DEPTH));
  assign rd_word = in_rng ? mem[adr_i] : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem_we   = 1'b0;
    mem_adr  = adr_i;
    mem_col  = wr_col_i;
    mem_wdat = wr_dat_i;
    rd_acc   = 1'b0;
    case (state_q)
      IDLE: begin
        mem_we = wr_ena_i & in_rng;
        rd_acc = rd_ena_i & ~wr_ena_i;
        if (clr_i) state_d = CLR;
      end
      CLR: begin
        mem_we   = 1'b1;
        mem_adr  = cnt_q;
        mem_col  = '1;
        mem_wdat = CLR_VAL;
        if (cnt_q == ADR_WD'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read strobe: rd_val_o is high for exactly one cycle per accepted read, and
  // rd_dat_o changes only in that cycle; no backpressure exists on the read side.
  always_comb begin
    s1_val_d = rd_acc;
    s1_dat_d = rd_acc ? rd_word : s1_dat_q;
    s2_val_d = s1_val_q;
    s2_dat_d = s1_val_q ? s1_dat_q : s2_dat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= (INIT_CLR != 0) ? CLR : IDLE;
      cnt_q    <= '0;
      s1_val_q <= 1'b0;
      s1_dat_q <= '0;
      s2_val_q <= 1'b0;
      s2_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s1_val_q <= s1_val_d;
      s1_dat_q <= s1_dat_d;
      s2_val_q <= s2_val_d;
      s2_dat_q <= s2_dat_d;
    end
  end

  // Storage core: reset never touches the array contents.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int c = 0; c < NCOL; c++) begin
        if (mem_col[c]) mem[mem_adr][c*COL_WD +: COL_WD] <= mem_wdat[c*COL_WD +: COL_WD];
      end
    end
  end

  assign rd_dat_o = (RD_LAT == 2) ? s2_dat_q : s1_dat_q;
  assign rd_val_o = (RD_LAT == 2) ? s2_val_q : s1_val_q;
  assign busy_o   = (state_q == CLR);

endmodule

// File: tb/tb_ram_sp_be_pipe.sv
// Bench for ram_sp_be_pipe: instance a uses defaults (RD_LAT=1, CLR_VAL=0),
// instance b uses RD_LAT=2 and CLR_VAL=0x5A5A5A5A.
module tb_ram_sp_be_pipe;

  localparam int OP_W = 0;
  localparam int OP_R = 1;
  localparam int OP_C = 2;

  typedef struct {
    int          op;
    logic [10:0] adr;
    logic [3:0]  col;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [10:0] a_adr, b_adr;
  logic        a_we, b_we, a_re, b_re, a_clr, b_clr;
  logic [3:0]  a_col, b_col;
  logic [31:0] a_wd, b_wd, a_rdat, b_rdat;
  logic        a_rval, b_rval, a_busy, b_busy;

  int n_vec = 0;
  int n_err = 0;
  vec_t vt[$];

  always #5 clk = ~clk;

  ram_sp_be_pipe u_a (
    .clk(clk), .rst(rst_a), .adr_i(a_adr), .wr_ena_i(a_we), .wr_col_i(a_col),
    .wr_dat_i(a_wd), .rd_ena_i(a_re), .rd_dat_o(a_rdat), .rd_val_o(a_rval),
    .clr_i(a_clr), .busy_o(a_busy)
  );

  ram_sp_be_pipe #(.RD_LAT(2), .CLR_VAL(32'h5A5A_5A5A)) u_b (
    .clk(clk), .rst(rst_b), .adr_i(b_adr), .wr_ena_i(b_we), .wr_col_i(b_col),
    .wr_dat_i(b_wd), .rd_ena_i(b_re), .rd_dat_o(b_rdat), .rd_val_o(b_rval),
    .clr_i(b_clr), .busy_o(b_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int s, input logic we, input logic re, input logic clr,
                     input logic [10:0] adr, input logic [3:0] col, input logic [31:0] dat);
    if (s == 0) begin
      a_we = we; a_re = re; a_clr = clr; a_adr = adr; a_col = col; a_wd = dat;
    end else begin
      b_we = we; b_re = re; b_clr = clr; b_adr = adr; b_col = col; b_wd = dat;
    end
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic rd_chk(input int s, input logic [10:0] adr, input logic [31:0] exp, input int idx);
    drv(s, 1'b0, 1'b1, 1'b0, adr, 4'h0, 32'h0);
    tick;
    drv(s, 1'b0, 1'b0, 1'b0, 11'd0, 4'h0, 32'h0);
    if (s == 1) tick;
    chk(s == 0 ? "a_rd_val" : "b_rd_val", idx, {31'b0, (s == 0) ? a_rval : b_rval}, 32'd1);
    chk(s == 0 ? "a_rd_dat" : "b_rd_dat", idx, (s == 0) ? a_rdat : b_rdat, exp);
  endtask

  function automatic void add(input int op, input logic [10:0] adr, input logic [3:0] col,
                              input logic [31:0] dat, input logic [31:0] exp);
    vec_t v;
    v.op = op; v.adr = adr; v.col = col; v.dat = dat; v.exp = exp;
    vt.push_back(v);
  endfunction

  initial begin
    int ia, ib, n;
    logic any_rv;
    logic [31:0] held;

    add(OP_R, 11'd0,    4'h0,    32'h0,         32'h0);
    add(OP_R, 11'd767,  4'h0,    32'h0,         32'h0);
    add(OP_R, 11'd1535, 4'h0,    32'h0,         32'h0);
    add(OP_W, 11'd5,    4'hF,    32'hAABBCCDD,  32'h0);
    add(OP_W, 11'd5,    4'b0101, 32'h11223344,  32'h0);
    add(OP_R, 11'd5,    4'h0,    32'h0,         32'hAA22CC44);
    add(OP_W, 11'd5,    4'h0,    32'hFFFFFFFF,  32'h0);
    add(OP_R, 11'd5,    4'h0,    32'h0,         32'hAA22CC44);
    add(OP_C, 11'd9,    4'hF,    32'hDEADBEEF,  32'h0);
    add(OP_R, 11'd9,    4'h0,    32'h0,         32'hDEADBEEF);
    add(OP_R, 11'd1600, 4'h0,    32'h0,         32'h0);
    add(OP_W, 11'd1600, 4'hF,    32'h12345678,  32'h0);
    add(OP_R, 11'd64,   4'h0,    32'h0,         32'h0);
    add(OP_R, 11'd1600, 4'h0,    32'h0,         32'h0);
    add(OP_W, 11'd7,    4'hF,    32'hCAFEF00D,  32'h0);
    add(OP_R, 11'd7,    4'h0,    32'h0,         32'hCAFEF00D);
    add(OP_W, 11'd1,    4'hF,    32'h1,         32'h0);
    add(OP_W, 11'd2,    4'hF,    32'h2,         32'h0);
    add(OP_W, 11'd3,    4'hF,    32'h3,         32'h0);
    add(OP_R, 11'd1,    4'h0,    32'h0,         32'h1);
    add(OP_R, 11'd2,    4'h0,    32'h0,         32'h2);
    add(OP_R, 11'd3,    4'h0,    32'h0,         32'h3);
    add(OP_W, 11'd8,    4'hF,    32'h8,         32'h0);

    // clock/reset
    drv(0, 1'b0, 1'b0, 1'b0, 11'd0, 4'h0, 32'h0);
    drv(1, 1'b0, 1'b0, 1'b0, 11'd0, 4'h0, 32'h0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) tick;
    chk("rst_a_rval", 0, {31'b0, a_rval}, 32'd0);
    chk("rst_a_rdat", 0, a_rdat, 32'h0);
    chk("rst_b_rval", 0, {31'b0, b_rval}, 32'd0);
    chk("rst_b_rdat", 0, b_rdat, 32'h0);
    chk("rst_a_busy", 0, {31'b0, a_busy}, 32'd1);
    chk("rst_b_busy", 0, {31'b0, b_busy}, 32'd1);

    // Initial sweeps; b gets a one-cycle reset at sweep cycle 700.
    rst_a = 1'b0;
    rst_b = 1'b0;
    ia = -1;
    ib = -1;
    for (int t = 0; t < 4000; t++) begin
      if (!a_busy && ia < 0) ia = t;
      if (!b_busy && ib < 0) ib = t;
      if (ia >= 0 && ib >= 0) break;
      rst_b = (t == 700);
      tick;
    end
    rst_b = 1'b0;
    chk("a_init_busy_len", 0, 32'(ia), 32'd1536);
    chk("b_rst_mid_sweep_idle", 0, 32'(ib), 32'd2237);

    // Table-driven pass on instance a (RD_LAT=1).
    held = 32'h0;
    foreach (vt[i]) begin
      drv(0, vt[i].op != OP_R, vt[i].op != OP_W, 1'b0, vt[i].adr, vt[i].col, vt[i].dat);
      tick;
      drv(0, 1'b0, 1'b0, 1'b0, 11'd0, 4'h0, 32'h0);
      chk("a_vec_rval", i, {31'b0, a_rval}, (vt[i].op == OP_R) ? 32'd1 : 32'd0);
      if (vt[i].op == OP_R) held = vt[i].exp;
      chk("a_vec_rdat", i, a_rdat, held);
    end

    // Instance b: swept value, then pipelined reads with RD_LAT=2.
    rd_chk(1, 11'd100, 32'h5A5A5A5A, 0);
    for (int k = 1; k <= 3; k++) begin
      drv(1, 1'b1, 1'b0, 1'b0, 11'(k), 4'hF, 32'(k));
      tick;
    end
    drv(1, 1'b0, 1'b1, 1'b0, 11'd1, 4'h0, 32'h0);
    tick;
    chk("b_lat_rval", 0, {31'b0, b_rval}, 32'd0);
    drv(1, 1'b0, 1'b1, 1'b0, 11'd2, 4'h0, 32'h0);
    tick;
    chk("b_lat_rval", 1, {31'b0, b_rval}, 32'd1);
    chk("b_lat_rdat", 1, b_rdat, 32'h1);
    drv(1, 1'b0, 1'b1, 1'b0, 11'd3, 4'h0, 32'h0);
    tick;
    chk("b_lat_rval", 2, {31'b0, b_rval}, 32'd1);
    chk("b_lat_rdat", 2, b_rdat, 32'h2);
    drv(1, 1'b0, 1'b0, 1'b0, 11'd0, 4'h0, 32'h0);
    tick;
    chk("b_lat_rval", 3, {31'b0, b_rval}, 32'd1);
    chk("b_lat_rdat", 3, b_rdat, 32'h3);
    tick;
    chk("b_hold_rval", 0, {31'b0, b_rval}, 32'd0);
    chk("b_hold_rdat", 0, b_rdat, 32'h3);

    // Fill b with ones, then clear on request with ignored accesses and a second clr_i.
    for (int k = 0; k < 1536; k++) begin
      drv(1, 1'b1, 1'b0, 1'b0, 11'(k), 4'hF, 32'hFFFFFFFF);
      tick;
    end
    drv(1, 1'b0, 1'b0, 1'b0, 11'd0, 4'h0, 32'h0);
    rd_chk(1, 11'd1535, 32'hFFFFFFFF, 1);
    drv(1, 1'b0, 1'b0, 1'b1, 11'd0, 4'h0, 32'h0);
    tick;
    n = 0;
    any_rv = 1'b0;
    while (b_busy && n < 4000) begin
      n++;
      if (b_rval) any_rv = 1'b1;
      drv(1, n[0], ~n[0], n == 500, 11'd10, 4'hF, 32'h0);
      tick;
    end
    drv(1, 1'b0, 1'b0, 1'b0, 11'd0, 4'h0, 32'h0);
    chk("b_clr_busy_len", 0, 32'(n), 32'd1536);
    chk("b_clr_no_rval", 0, {31'b0, any_rv}, 32'd0);
    rd_chk(1, 11'd0,    32'h5A5A5A5A, 2);
    rd_chk(1, 11'd10,   32'h5A5A5A5A, 3);
    rd_chk(1, 11'd768,  32'h5A5A5A5A, 4);
    rd_chk(1, 11'd1535, 32'h5A5A5A5A, 5);
    rd_chk(1, 11'd1700, 32'h0,        6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
